// File: rtl/multichannel_conv_dotprod.sv
// Multichannel convolution dot-product engine.
// Each channel accumulates KERNEL_WIDTH^2 window-serial products; the
// completed per-channel dot products and their cross-channel sum are
// presented on a valid/ready output. The input stalls while a result is
// pending, so there is no skid buffer.
module multichannel_conv_dotprod #(
    parameter int BITWIDTH     = 8,
    parameter int KERNEL_WIDTH = 3,
    parameter int NUM_CHANNELS = 3,
    parameter int SIGNED_MODE  = 0,
    localparam int TAPS  = KERNEL_WIDTH * KERNEL_WIDTH,
    localparam int ACC_W = 2 * BITWIDTH + $clog2(TAPS) + SIGNED_MODE,
    localparam int SUM_W = ACC_W + $clog2(NUM_CHANNELS),
    localparam int TI_W  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_CHANNELS*BITWIDTH-1:0] data_in,
    input  logic [NUM_CHANNELS*BITWIDTH-1:0] filter_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             clear,
    output logic [NUM_CHANNELS*ACC_W-1:0]    dotproduct,
    output logic [SUM_W-1:0]                 channel_sum,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TI_W-1:0]                  tap_index,
    output logic [15:0]                      window_count
);

    localparam int PROD_W = 2 * BITWIDTH;
    localparam logic [TI_W-1:0] LAST_TAP = TI_W'(TAPS - 1);

    logic [TI_W-1:0]               tap_reg;
    logic [ACC_W-1:0]              acc_reg [NUM_CHANNELS];
    logic [NUM_CHANNELS*ACC_W-1:0] dot_reg;
    logic [SUM_W-1:0]              sum_reg;
    logic                          out_valid_reg;
    logic [15:0]                   window_count_reg;

    logic [ACC_W-1:0] acc_next [NUM_CHANNELS];
    logic [SUM_W-1:0] chan_ext [NUM_CHANNELS];
    logic [SUM_W-1:0] sum_next;
    logic             accept;
    logic             first_beat;
    logic             last_beat;

    // A pending, unconsumed result blocks all input.
    assign in_ready   = !(out_valid_reg && !out_ready);
    assign accept     = in_valid && in_ready && !clear;
    assign first_beat = (tap_reg == '0);
    assign last_beat  = (tap_reg == LAST_TAP);

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            logic [BITWIDTH-1:0] d;
            logic [BITWIDTH-1:0] f;
            logic [ACC_W-1:0]    prod_ext;

            assign d = data_in[gi*BITWIDTH +: BITWIDTH];
            assign f = filter_in[gi*BITWIDTH +: BITWIDTH];

            if (SIGNED_MODE != 0) begin : g_signed
                logic signed [PROD_W-1:0] prod;
                assign prod          = PROD_W'($signed(d)) * PROD_W'($signed(f));
                assign prod_ext      = ACC_W'(prod);
                assign chan_ext[gi]  = SUM_W'($signed(acc_next[gi]));
            end else begin : g_unsigned
                logic [PROD_W-1:0] prod;
                assign prod          = PROD_W'(d) * PROD_W'(f);
                assign prod_ext      = ACC_W'(prod);
                assign chan_ext[gi]  = SUM_W'(acc_next[gi]);
            end

            // The first beat of a window overwrites, so no stale partial sum leaks in.
            assign acc_next[gi] = (first_beat ? '0 : acc_reg[gi]) + prod_ext;
        end
    endgenerate

    // Cross-channel sum of the updated accumulators.
    always_comb begin
        sum_next = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sum_next = sum_next + chan_ext[c];
        end
    end

    // Window sequencing, accumulation and result/handshake registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            tap_reg          <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc_reg[c] <= '0;
            end
            dot_reg          <= '0;
            sum_reg          <= '0;
            out_valid_reg    <= 1'b0;
            window_count_reg <= '0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (clear) begin
                tap_reg <= '0;
            end else if (accept) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    acc_reg[c] <= acc_next[c];
                end
                if (last_beat) begin
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        dot_reg[c*ACC_W +: ACC_W] <= acc_next[c];
                    end
                    sum_reg          <= sum_next;
                    out_valid_reg    <= 1'b1;
                    tap_reg          <= '0;
                    window_count_reg <= window_count_reg + 16'd1;
                end else begin
                    tap_reg <= tap_reg + TI_W'(1);
                end
            end
        end
    end

    assign dotproduct   = dot_reg;
    assign channel_sum  = sum_reg;
    assign out_valid    = out_valid_reg;
    assign tap_index    = tap_reg;
    assign window_count = window_count_reg;

endmodule

// File: tb/tb_multichannel_conv_dotprod.sv
// Self-checking bench: an unsigned instance driven against a window-level
// reference model, plus a signed instance checked on whole windows.
module tb_multichannel_conv_dotprod;

    localparam int B     = 8;
    localparam int N     = 3;
    localparam int TAPS  = 9;
    localparam int ACC_U = 20;
    localparam int SUM_U = 22;
    localparam int ACC_S = 21;
    localparam int SUM_S = 23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [N*B-1:0]   data_u, filt_u;
    logic             in_valid_u, in_ready_u, clear_u, out_valid_u, out_ready_u;
    logic [N*ACC_U-1:0] dot_u;
    logic [SUM_U-1:0] sum_u;
    logic [3:0]       tap_u;
    logic [15:0]      wc_u;

    logic [N*B-1:0]   data_s, filt_s;
    logic             in_valid_s, in_ready_s, clear_s, out_valid_s, out_ready_s;
    logic [N*ACC_S-1:0] dot_s;
    logic [SUM_S-1:0] sum_s;
    logic [3:0]       tap_s;
    logic [15:0]      wc_s;

    multichannel_conv_dotprod #(
        .BITWIDTH(B), .KERNEL_WIDTH(3), .NUM_CHANNELS(N), .SIGNED_MODE(0)
    ) u_dut (
        .clock(clk), .reset(reset), .data_in(data_u), .filter_in(filt_u),
        .in_valid(in_valid_u), .in_ready(in_ready_u), .clear(clear_u),
        .dotproduct(dot_u), .channel_sum(sum_u), .out_valid(out_valid_u),
        .out_ready(out_ready_u), .tap_index(tap_u), .window_count(wc_u)
    );

    multichannel_conv_dotprod #(
        .BITWIDTH(B), .KERNEL_WIDTH(3), .NUM_CHANNELS(N), .SIGNED_MODE(1)
    ) s_dut (
        .clock(clk), .reset(reset), .data_in(data_s), .filter_in(filt_s),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .clear(clear_s),
        .dotproduct(dot_s), .channel_sum(sum_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .tap_index(tap_s), .window_count(wc_s)
    );

    int errors = 0;
    int checks = 0;

    // Window-level reference model of the unsigned instance.
    longint m_part [N];
    longint m_dot  [N];
    longint m_sum;
    int     m_cnt;
    bit     m_valid;
    int     m_wc;
    int     s_wc;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
        end
    endtask

    function automatic logic [N*B-1:0] rep(input logic [B-1:0] v);
        return {N{v}};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_part[c] = 0;
            m_dot[c]  = 0;
        end
        m_sum = 0; m_cnt = 0; m_valid = 0; m_wc = 0; s_wc = 0;
    endtask

    task automatic check_u_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid_u), 64'(m_valid));
        check({tag, ".tap_index"}, 64'(tap_u), 64'(m_cnt));
        check({tag, ".window_count"}, 64'(wc_u), 64'(m_wc));
        for (int c = 0; c < N; c++) begin
            check($sformatf("%s.dot[%0d]", tag, c), 64'(dot_u[c*ACC_U +: ACC_U]), m_dot[c]);
        end
        check({tag, ".channel_sum"}, 64'(sum_u), m_sum);
    endtask

    // One clock of the unsigned instance; called and returns at a falling edge.
    task automatic cycle_u(input string tag, input bit v, input bit clr, input bit ordy,
                           input logic [N*B-1:0] dpk, input logic [N*B-1:0] fpk);
        bit exp_rdy;
        in_valid_u = v; clear_u = clr; out_ready_u = ordy; data_u = dpk; filt_u = fpk;
        exp_rdy = !(m_valid && !ordy);
        #1;
        check({tag, ".in_ready"}, 64'(in_ready_u), 64'(exp_rdy));
        @(posedge clk);
        if (m_valid && ordy) begin
            $display("consumed result: window_count=%0d channel_sum=%0d", m_wc, m_sum);
            m_valid = 0;
        end
        if (clr) begin
            m_cnt = 0;
        end else if (v && exp_rdy) begin
            for (int c = 0; c < N; c++) begin
                longint p;
                p = longint'(dpk[c*B +: B]) * longint'(fpk[c*B +: B]);
                m_part[c] = ((m_cnt == 0) ? 64'sd0 : m_part[c]) + p;
            end
            m_cnt++;
            if (m_cnt == TAPS) begin
                m_sum = 0;
                for (int c = 0; c < N; c++) begin
                    m_dot[c] = m_part[c];
                    m_sum    = m_sum + m_part[c];
                end
                m_valid = 1;
                m_wc    = (m_wc + 1) % 65536;
                m_cnt   = 0;
            end
        end
        @(negedge clk);
        check_u_outputs(tag);
        in_valid_u = 1'b0; clear_u = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid_u = 1'b0; clear_u = 1'b0; in_valid_s = 1'b0; clear_s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_u_outputs("reset");
        check("reset.s_out_valid", 64'(out_valid_s), 64'sd0);
        check("reset.s_window_count", 64'(wc_s), 64'sd0);
        $display("reset applied");
    endtask

    // One full window on the signed instance with out_ready held high.
    task automatic signed_window(input bit rnd);
        longint e [N];
        longint es;
        logic [N*B-1:0] dpk, fpk;
        for (int c = 0; c < N; c++) e[c] = 0;
        for (int t = 0; t < TAPS; t++) begin
            if (rnd) begin
                dpk = (N*B)'($urandom());
                fpk = (N*B)'($urandom());
            end else begin
                dpk = {8'h00, 8'h80, 8'h80};
                fpk = {8'h05, 8'h7F, 8'h80};
            end
            for (int c = 0; c < N; c++) begin
                e[c] = e[c] + longint'($signed(dpk[c*B +: B])) * longint'($signed(fpk[c*B +: B]));
            end
            in_valid_s = 1'b1; out_ready_s = 1'b1; data_s = dpk; filt_s = fpk;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid_s = 1'b0;
        s_wc++;
        es = 0;
        for (int c = 0; c < N; c++) es = es + e[c];
        check("signed.out_valid", 64'(out_valid_s), 64'sd1);
        check("signed.window_count", 64'(wc_s), 64'(s_wc));
        check("signed.tap_index", 64'(tap_s), 64'sd0);
        for (int c = 0; c < N; c++) begin
            check($sformatf("signed.dot[%0d]", c), 64'($signed(dot_s[c*ACC_S +: ACC_S])), e[c]);
        end
        check("signed.channel_sum", 64'($signed(sum_s)), es);
        $display("signed window %0d: sum=%0d", s_wc, es);
    endtask

    initial begin
        data_u = '0; filt_u = '0; in_valid_u = 0; clear_u = 0; out_ready_u = 0;
        data_s = '0; filt_s = '0; in_valid_s = 0; clear_s = 0; out_ready_s = 0;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // All-ones window.
        for (int t = 0; t < TAPS; t++) cycle_u("ones", 1, 0, 1, rep(8'd1), rep(8'd1));
        check("ones.dot0", 64'(dot_u[0 +: ACC_U]), 64'sd9);
        check("ones.sum", 64'(sum_u), 64'sd27);
        check("ones.wc", 64'(wc_u), 64'sd1);

        // Maximum operands: no wrap at ACC_W / SUM_W.
        for (int t = 0; t < TAPS; t++) cycle_u("max", 1, 0, 1, rep(8'd255), rep(8'd255));
        check("max.dot2", 64'(dot_u[2*ACC_U +: ACC_U]), 64'sd585225);
        check("max.sum", 64'(sum_u), 64'sd1755675);

        // Backpressure: result 1 held while window 2 is presented.
        for (int t = 0; t < TAPS; t++)
            cycle_u("bp.w1", 1, 0, 0, (N*B)'($urandom()), (N*B)'($urandom()));
        for (int t = 0; t < 5; t++)
            cycle_u("bp.hold", 1, 0, 0, (N*B)'($urandom()), (N*B)'($urandom()));
        for (int t = 0; t < TAPS; t++)
            cycle_u("bp.w2", 1, 0, 1, (N*B)'($urandom()), (N*B)'($urandom()));
        cycle_u("bp.drain", 0, 0, 1, '0, '0);

        // Back-to-back windows at full throughput.
        for (int t = 0; t < 3 * TAPS; t++)
            cycle_u("b2b", 1, 0, 1, (N*B)'($urandom()), (N*B)'($urandom()));
        cycle_u("b2b.drain", 0, 0, 1, '0, '0);

        // Clear at tap 4 with a beat in flight, then a clean window.
        for (int t = 0; t < 4; t++) cycle_u("clr.pre", 1, 0, 1, rep(8'd10), rep(8'd3));
        cycle_u("clr", 1, 1, 1, rep(8'd10), rep(8'd3));
        for (int t = 0; t < TAPS; t++) cycle_u("clr.win", 1, 0, 1, rep(8'd1), rep(8'd2));
        check("clr.dot1", 64'(dot_u[ACC_U +: ACC_U]), 64'sd18);
        check("clr.sum", 64'(sum_u), 64'sd54);

        // Reset at tap 6, then a full window.
        for (int t = 0; t < 6; t++)
            cycle_u("rst.pre", 1, 0, 1, (N*B)'($urandom()), (N*B)'($urandom()));
        do_reset();
        for (int t = 0; t < TAPS; t++)
            cycle_u("rst.win", 1, 0, 1, (N*B)'($urandom()), (N*B)'($urandom()));
        check("rst.wc", 64'(wc_u), 64'sd1);

        // Random traffic with gaps, stalls and occasional clears.
        for (int t = 0; t < 150; t++)
            cycle_u("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                    $urandom_range(0, 3) != 0, (N*B)'($urandom()), (N*B)'($urandom()));

        // Signed instance.
        signed_window(0);
        check("signed.ch0", 64'($signed(dot_s[0 +: ACC_S])), 64'sd147456);
        check("signed.ch1", 64'($signed(dot_s[ACC_S +: ACC_S])), -64'sd146304);
        check("signed.ch2", 64'($signed(dot_s[2*ACC_S +: ACC_S])), 64'sd0);
        check("signed.sum", 64'($signed(sum_s)), 64'sd1152);
        for (int w = 0; w < 4; w++) signed_window(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multichannel_conv_dotprod.md
Name: multichannel_conv_dotprod

Overview:
- Parametrised successor to the fixed three-channel (R/G/B) convolution dot-product arrangement.
- Takes NUM_CHANNELS channels of window-serial pixel/filter beats in parallel. Each channel accumulates KERNEL_WIDTH*KERNEL_WIDTH products per window.
- Outputs per-channel dot products and their cross-channel sum through a valid/ready handshake.
- Sits between the tensor/filter streaming front end and the activation/output stage of the convolution datapath.

Parameters:
- BITWIDTH, 8: width of one pixel or filter element per channel.
- KERNEL_WIDTH, 3: filter is KERNEL_WIDTH x KERNEL_WIDTH. Window length TAPS = KERNEL_WIDTH^2 beats.
- NUM_CHANNELS, 3: number of parallel channels, minimum 1.
- SIGNED_MODE, 0: 0 = unsigned operands and products; 1 = two's-complement operands and products.
- Derived localparam ACC_W = 2*BITWIDTH + $clog2(TAPS) + SIGNED_MODE.
- Derived localparam SUM_W = ACC_W + $clog2(NUM_CHANNELS), with a minimum of ACC_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  NUM_CHANNELS*BITWIDTH  pixel beat; channel c occupies bits [c*BITWIDTH +: BITWIDTH].
- filter_in  in  NUM_CHANNELS*BITWIDTH  filter beat, same packing as data_in.
- in_valid  in  1  data_in/filter_in hold a valid beat.
- in_ready  out  1  block can accept a beat this cycle.
- clear  in  1  discards the partial window.
- dotproduct  out  NUM_CHANNELS*ACC_W  per-channel result, packed like data_in.
- channel_sum  out  SUM_W  sum of all channel dot products.
- out_valid  out  1  dotproduct and channel_sum are valid.
- out_ready  in  1  consumer accepts the result.
- tap_index  out  $clog2(TAPS)  index of the next beat within the current window.
- window_count  out  16  number of completed windows; wraps modulo 2^16.

Behaviour:
- Reset (synchronous, active-high) takes priority over all other inputs. Reset values: tap_index=0, all accumulators=0, dotproduct=0, channel_sum=0, out_valid=0, window_count=0. in_ready is 1 on the first cycle after reset deasserts.
- in_ready = !(out_valid && !out_ready). The block holds off all input while an unconsumed result is pending. There is no skid buffer.
- A beat is accepted when in_valid && in_ready.
- Per-channel product is data*filter at 2*BITWIDTH width, sign-extended when SIGNED_MODE=1 and zero-extended when SIGNED_MODE=0.
- The accumulator is ACC_W wide. Overflow cannot occur by construction.
- Accepted beat with tap_index==0: acc[c] <= product[c] (overwrite, no stale carry-over). tap_index <= 1.
- Accepted beat with 0<tap_index<TAPS-1: acc[c] <= acc[c]+product[c]. tap_index increments.
- Accepted beat with tap_index==TAPS-1:
  - dotproduct[c] <= acc[c]+product[c].
  - channel_sum <= sum over c of (acc[c]+product[c]), sign-extended to SUM_W.
  - out_valid <= 1, tap_index <= 0, window_count increments.
- Latency: the result is visible one cycle after the last beat is accepted.
- TAPS==1 case: every accepted beat is both first and last beat of a window.
- out_valid && out_ready with no new last beat in the same cycle: out_valid <= 0. Outputs keep their last values; they are not cleared.
- out_valid && out_ready coincident with an accepted last beat (in_ready is 1 because out_ready is 1): the new result loads and out_valid stays 1. Back-to-back windows therefore run at full throughput.
- While out_valid && !out_ready: dotproduct and channel_sum are held stable. No beat is accepted.
- clear asserted: tap_index <= 0 and any beat presented that cycle is dropped. in_ready is unaffected. Pending out_valid/results and window_count are unaffected.
- Reset mid-window: partial accumulation is lost and no result is produced.

Test Plan:
- Unsigned, K=3, N=3, B=8. 9 beats of all-ones data and filter with out_ready=1 -> one cycle after beat 9: out_valid=1, each dotproduct=9, channel_sum=27, window_count=1.
- Unsigned max. 9 beats of data=255, filter=255 on all channels -> each dotproduct=585225, channel_sum=1755675 (ACC_W=20 and SUM_W=22, no wrap).
- SIGNED_MODE=1, 9 beats of ch0 data=-128, filter=-128; ch1 data=-128, filter=127; ch2 data=0 -> ch0=147456, ch1=-146304, ch2=0, channel_sum=1152.
- Backpressure. Two windows streamed continuously with out_ready=0 after the first result -> in_ready=0 and result 1 held stable for 5 cycles. Raise out_ready -> result 1 consumed, window 2 then completes correctly, window_count=2.
- Back-to-back windows with out_ready=1 -> results on consecutive 9-cycle boundaries with no bubble; out_valid stays high across the handoff.
- clear asserted at tap_index=4 (data=10 in flight), then a full window of data=1, filter=2 -> dotproduct=18 per channel. Separately, reset at tap 6 then a full window -> the first result reflects only the post-reset window.
